oram_path_engine: RTL
=====================

// Module: oram_path_engine
// PURPOSE
//  Parametrised Path-ORAM access engine: next generation of oram_module, same request/response handshake.
//  Holds a binary bucket tree (Z slots/bucket), a position map, a stash and an LFSR leaf remapper on chip.
//  Each access reads one full root-to-leaf path into the stash, serves the block, remaps it, evicts the path back.
//  Sits between the client request port and (later) an external tree memory; here the tree is internal.
// PARAMETERS
//  BLK_BYTES  4       block size in bytes (data width 8*BLK_BYTES); matches oramPkg::a
//  ADDR_W     3       block address width; 2**ADDR_W blocks; matches oramPkg::d
//  L          ADDR_W  tree depth; levels 0..L, 2**L leaves, 2**(L+1)-1 buckets
//  Z          4       slots per bucket
//  STASH_N    24      stash entries (must be >= (L+1)*Z)
//  LFSR_SEED  'h1     nonzero reset seed of 16-bit Fibonacci LFSR (taps 16,14,13,11)
// PORTS
//  clk            in   1            clock, all logic rising-edge
//  rst            in   1            synchronous reset, active-high
//  block_num      in   ADDR_W       logical block address, sampled on accept
//  write_val      in   8*BLK_BYTES  write data, sampled on accept
//  rw_indicator   in   1            1 = write, 0 = read, sampled on accept
//  input_ready    in   1            request valid
//  req_ready      out  1            engine idle, request accepted when input_ready & req_ready
//  read_val       out  8*BLK_BYTES  block content before the access (valid with output_ready)
//  output_ready   out  1            one-cycle completion pulse
//  stash_overflow out  1            sticky: a valid path slot or new block found no free stash entry
// BEHAVIOUR
//  Reset (sync, rst=1): state IDLE; req_ready=1 on first cycle after rst low; output_ready=0; read_val=0;
//   stash_overflow=0; all tree slot valids and stash valids cleared; posmap[i]=i mod 2**L; LFSR=LFSR_SEED.
//  Reset mid-operation: access aborted, no output_ready, all contents lost (same as power-up reset).
//  States: IDLE -> POSMAP -> READ_PATH -> UPDATE -> EVICT -> DONE -> IDLE.
//   IDLE: req_ready=1; on accept latch addr/data/rw; requests while req_ready=0 are ignored (not queued).
//   POSMAP (1 cyc): x = posmap[addr]; posmap[addr] <= LFSR[L-1:0]; LFSR advances one step.
//   READ_PATH ((L+1)*Z cyc): level k=0..L, slot s=0..Z-1, one slot/cycle; bucket idx = 2**k-1 + (x>>(L-k));
//    valid slot moved into lowest free stash entry, slot valid cleared; no free entry -> stash_overflow=1, slot dropped.
//   UPDATE (1 cyc): search stash for addr. Hit: read_val<=data; leaf<=new leaf; write overwrites data.
//    Miss (never written): read_val<=0; allocate entry {addr,new leaf,data = write ? write_val : 0};
//    no free entry -> stash_overflow=1, access still completes with read_val=0.
//   EVICT ((L+1)*Z cyc): level k=L down to 0, slot s=0..Z-1; pick lowest-index valid stash entry with
//    (leaf>>(L-k)) == (x>>(L-k)); write it to slot, free stash entry; none eligible -> slot written invalid.
//   DONE (1 cyc): output_ready=1, read_val stable; read_val holds until next UPDATE.
//  Latency: accept edge to output_ready = 2*(L+1)*Z + 3 cycles, fixed, independent of data (obliviousness).
//  Defaults: 2*4*4+3 = 35 cycles. Eligibility check uses L-bit unsigned shifts; k=0 matches every entry.
//  Address width: bucket index $clog2(2**(L+1)-1) bits; stash index $clog2(STASH_N) bits.
//  Tree slot: {valid, addr[ADDR_W], leaf[L], data[8*BLK_BYTES]}; valids in flops (1-cycle clear), rest in array.
// STRUCTURE
//  oramPkg gains: typedef oram_slot_t (slot struct), typedef oram_state_e, function bucket_idx(k,x).
//  One sub-module: oram_stash (STASH_N entries; lowest-free alloc, addr lookup, eligible-pick per level).
//  Tree array, posmap, LFSR, FSM and counters live in oram_path_engine.
// TESTING
//  1 write block 1 = 2, then block 3 = 10, then read block 1 -> read_val=2, output_ready 35 cyc after accept.
//  2 read block 5 never written -> read_val=0; following read block 5 -> 0; write 7 then read -> 7.
//  3 input_ready held high through busy -> exactly one access per IDLE, req_ready=0 between accept and DONE.
//  4 rst pulse mid READ_PATH after writing block 1=2 -> no output_ready; subsequent read block 1 -> 0.
//  5 1000 random r/w over all 8 blocks vs scoreboard model -> all reads match, stash_overflow=0 (STASH_N=24).
//  6 white-box: posmap[addr] after access equals LFSR value in POSMAP; every valid tree slot on its leaf's path.

Source files
------------

// File: rtl/oram_path_engine_pkg.sv
// Shared types and default geometry for the Path-ORAM access engine.
package oram_path_engine_pkg;

  localparam int ORAM_BLK_BYTES = 4;
  localparam int ORAM_ADDR_W    = 3;
  localparam int ORAM_L         = ORAM_ADDR_W;
  localparam int ORAM_Z         = 4;
  localparam int ORAM_STASH_N   = 24;
  localparam int ORAM_DATA_W    = 8 * ORAM_BLK_BYTES;
  localparam int ORAM_NBKT      = 2 ** (ORAM_L + 1) - 1;
  localparam int ORAM_BKT_W     = $clog2(ORAM_NBKT);
  localparam int ORAM_LVL_W     = $clog2(ORAM_L + 1);

  // One tree slot / stash entry
  typedef struct packed {
    logic                   valid;
    logic [ORAM_ADDR_W-1:0] addr;
    logic [ORAM_L-1:0]      leaf;
    logic [ORAM_DATA_W-1:0] data;
  } oram_slot_t;

  typedef enum logic [2:0] {
    S_IDLE, S_POSMAP, S_READ, S_UPDATE, S_EVICT, S_DONE
  } oram_state_e;

  // Bucket on level k of the path to leaf x: heap-ordered tree, root = 0
  function automatic logic [ORAM_BKT_W-1:0] bucket_idx(input logic [ORAM_LVL_W-1:0] k,
                                                       input logic [ORAM_L-1:0]     x);
    logic [ORAM_LVL_W-1:0] sh;
    logic [ORAM_L-1:0]     node;
    sh   = ORAM_LVL_W'(ORAM_L) - k;
    node = x >> sh;
    return ORAM_BKT_W'((1 << k) - 1) + ORAM_BKT_W'(node);
  endfunction

endpackage

// File: rtl/oram_path_engine_stash.sv
// Stash: lowest-free allocation, address lookup and per-level eviction pick.
module oram_path_engine_stash
  import oram_path_engine_pkg::*;
#(
  parameter int N  = ORAM_STASH_N,
  parameter int IW = $clog2(N)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ORAM_ADDR_W-1:0] lookup_addr,
  input  logic [ORAM_LVL_W-1:0]  level,
  input  logic [ORAM_L-1:0]      path_leaf,
  input  logic                   wr_en,
  input  logic [IW-1:0]          wr_idx,
  input  oram_slot_t             wr_ent,
  input  logic                   clr_en,
  input  logic [IW-1:0]          clr_idx,
  output logic                   free_ok,
  output logic [IW-1:0]          free_idx,
  output logic                   hit_ok,
  output logic [IW-1:0]          hit_idx,
  output logic [ORAM_DATA_W-1:0] hit_data,
  output logic                   elig_ok,
  output logic [IW-1:0]          elig_idx,
  output oram_slot_t             elig_ent
);

  oram_slot_t            ent [N];
  logic [ORAM_LVL_W-1:0] sh;

  assign sh = ORAM_LVL_W'(ORAM_L) - level;

  // Entry storage: only valid bits are reset, payload is don't-care when invalid
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) ent[i].valid <= 1'b0;
    end else begin
      if (wr_en) ent[wr_idx] <= wr_ent;
      if (clr_en) ent[clr_idx].valid <= 1'b0;
    end
  end

  // Priority scans; descending loop so the lowest matching index wins
  always_comb begin
    free_ok  = 1'b0;
    free_idx = '0;
    hit_ok   = 1'b0;
    hit_idx  = '0;
    elig_ok  = 1'b0;
    elig_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!ent[i].valid) begin
        free_ok  = 1'b1;
        free_idx = IW'(i);
      end
      if (ent[i].valid && ent[i].addr == lookup_addr) begin
        hit_ok  = 1'b1;
        hit_idx = IW'(i);
      end
      if (ent[i].valid && ((ent[i].leaf >> sh) == (path_leaf >> sh))) begin
        elig_ok  = 1'b1;
        elig_idx = IW'(i);
      end
    end
    hit_data = ent[hit_idx].data;
    elig_ent = ent[elig_idx];
  end

endmodule

// File: rtl/oram_path_engine.sv
// Path-ORAM access engine: read path to stash, serve/remap block, evict path.
module oram_path_engine
  import oram_path_engine_pkg::*;
#(
  parameter int          BLK_BYTES = ORAM_BLK_BYTES,
  parameter int          ADDR_W    = ORAM_ADDR_W,
  parameter int          L         = ADDR_W,
  parameter int          Z         = ORAM_Z,
  parameter int          STASH_N   = ORAM_STASH_N,
  parameter logic [15:0] LFSR_SEED = 16'h1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_W-1:0]      block_num,
  input  logic [8*BLK_BYTES-1:0] write_val,
  input  logic                   rw_indicator,
  input  logic                   input_ready,
  output logic                   req_ready,
  output logic [8*BLK_BYTES-1:0] read_val,
  output logic                   output_ready,
  output logic                   stash_overflow
);

  localparam int DW   = 8 * BLK_BYTES;
  localparam int NBLK = 2 ** ADDR_W;
  localparam int NBKT = 2 ** (L + 1) - 1;
  localparam int BW   = $clog2(NBKT);
  localparam int LW   = $clog2(L + 1);
  localparam int SW   = $clog2(Z);
  localparam int IW   = $clog2(STASH_N);

  oram_state_e state, state_nx;

  logic [LW-1:0]          lvl, k;
  logic [SW-1:0]          slot;
  logic                   last;
  logic [ADDR_W-1:0]      addr_q;
  logic [DW-1:0]          data_q;
  logic                   rw_q;
  logic [L-1:0]           path_x, new_leaf;
  logic [15:0]            lfsr, lfsr_nx;
  logic [L-1:0]           posmap [NBLK];
  logic [NBKT-1:0][Z-1:0] tree_vld;
  oram_slot_t             tree_mem [NBKT][Z];
  logic [BW-1:0]          bidx;
  oram_slot_t             path_slot;

  logic                   wr_en, clr_en;
  logic [IW-1:0]          wr_idx;
  oram_slot_t             wr_ent;
  logic                   free_ok, hit_ok, elig_ok;
  logic [IW-1:0]          free_idx, hit_idx, elig_idx;
  logic [DW-1:0]          hit_data;
  oram_slot_t             elig_ent;

  // Eviction walks leaf-to-root so deep slots get first pick of the stash
  assign k         = (state == S_EVICT) ? LW'(L) - lvl : lvl;
  assign bidx      = bucket_idx(k, path_x);
  assign last      = (lvl == LW'(L)) && (slot == SW'(Z - 1));
  assign path_slot = tree_mem[bidx][slot];
  assign req_ready = (state == S_IDLE);
  assign lfsr_nx   = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

  oram_path_engine_stash #(.N(STASH_N), .IW(IW)) u_stash (
    .clk        (clk),
    .rst        (rst),
    .lookup_addr(addr_q),
    .level      (k),
    .path_leaf  (path_x),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .wr_ent     (wr_ent),
    .clr_en     (clr_en),
    .clr_idx    (elig_idx),
    .free_ok    (free_ok),
    .free_idx   (free_idx),
    .hit_ok     (hit_ok),
    .hit_idx    (hit_idx),
    .hit_data   (hit_data),
    .elig_ok    (elig_ok),
    .elig_idx   (elig_idx),
    .elig_ent   (elig_ent)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next state: fixed-length walk, no data-dependent exits
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (input_ready) state_nx = S_POSMAP;
      S_POSMAP: state_nx = S_READ;
      S_READ:   if (last) state_nx = S_UPDATE;
      S_UPDATE: state_nx = S_EVICT;
      S_EVICT:  if (last) state_nx = S_DONE;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Stash write/clear strobes per state
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = free_idx;
    wr_ent = path_slot;
    clr_en = 1'b0;
    case (state)
      S_READ:   wr_en = tree_vld[bidx][slot] & free_ok;
      S_UPDATE: begin
        wr_en       = hit_ok | free_ok;
        if (hit_ok) wr_idx = hit_idx;
        wr_ent.valid = 1'b1;
        wr_ent.addr  = addr_q;
        wr_ent.leaf  = new_leaf;
        wr_ent.data  = rw_q ? data_q : (hit_ok ? hit_data : '0);
      end
      S_EVICT:  clr_en = elig_ok;
      default:  ;
    endcase
  end

  // Control datapath: request latch, posmap/LFSR, slot counters, tree valids
  always_ff @(posedge clk) begin
    if (rst) begin
      lvl            <= '0;
      slot           <= '0;
      addr_q         <= '0;
      data_q         <= '0;
      rw_q           <= 1'b0;
      path_x         <= '0;
      new_leaf       <= '0;
      lfsr           <= LFSR_SEED;
      read_val       <= '0;
      output_ready   <= 1'b0;
      stash_overflow <= 1'b0;
      tree_vld       <= '0;
      for (int i = 0; i < NBLK; i++) posmap[i] <= L'(i);
    end else begin
      // Registered pulse: lands on the cycle after DONE, 35 edges after accept
      output_ready <= (state == S_DONE);
      if (state == S_READ || state == S_EVICT) begin
        if (last) begin
          lvl  <= '0;
          slot <= '0;
        end else if (slot == SW'(Z - 1)) begin
          slot <= '0;
          lvl  <= lvl + 1'b1;
        end else begin
          slot <= slot + 1'b1;
        end
      end
      case (state)
        S_IDLE: if (input_ready) begin
          addr_q <= block_num;
          data_q <= write_val;
          rw_q   <= rw_indicator;
        end
        S_POSMAP: begin
          path_x         <= posmap[addr_q];
          posmap[addr_q] <= lfsr[L-1:0];
          new_leaf       <= lfsr[L-1:0];
          lfsr           <= lfsr_nx;
        end
        S_READ: if (tree_vld[bidx][slot]) begin
          tree_vld[bidx][slot] <= 1'b0;
          if (!free_ok) stash_overflow <= 1'b1;
        end
        S_UPDATE: begin
          read_val <= hit_ok ? hit_data : '0;
          if (!hit_ok && !free_ok) stash_overflow <= 1'b1;
        end
        S_EVICT: tree_vld[bidx][slot] <= elig_ok;
        default: ;
      endcase
    end
  end

  // Tree payload array; meaning gated by tree_vld, so no reset
  always_ff @(posedge clk) begin
    if (state == S_EVICT && elig_ok) tree_mem[bidx][slot] <= elig_ent;
  end

endmodule
